// File: rtl/mux2_arb_4b_pkg.sv
// Shared types and constants for the two-requester arbiter with a one-entry output buffer.
package mux2_arb_4b_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // Saturating increment: the transfer counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mux2_arb_4b_mux.sv
// Gate-level 2:1 data mux, DATA_W bits wide: y = sel ? b : a.
module mux2_arb_4b_mux
    import mux2_arb_4b_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] y
);

    wire              sel_n;
    wire [DATA_W-1:0] a_term;
    wire [DATA_W-1:0] b_term;
    wire [DATA_W-1:0] y_w;

    not u_inv (sel_n, sel);

    genvar i;
    generate
        for (i = 0; i < DATA_W; i++) begin : g_bit
            and u_and_a (a_term[i], a[i], sel_n);
            and u_and_b (b_term[i], b[i], sel);
            or  u_or    (y_w[i], a_term[i], b_term[i]);
        end
    endgenerate

    assign y = y_w;

endmodule

// File: rtl/mux2_arb_4b.sv
// Two-requester arbiter feeding a one-entry output buffer, round-robin by default.
// Define MUX2_ARB_4B_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 wins).
module mux2_arb_4b
    import mux2_arb_4b_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_val,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_rdy,
    input  logic              in1_val,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_rdy,
    output logic              out_val,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_rdy,
    output logic [CNT_W-1:0]  xfer_cnt
);

    // Handshake: a transfer happens on any cycle where valid and ready are both 1.
    // Valid never waits on ready; ready here is combinational from the valids,
    // out_rdy, buffer state and priority pointer, never from the payload.

    buf_state_t        state;
    logic              buf_free;
    logic              grant0;
    logic              grant1;
    logic              xfer_in;
    logic [DATA_W-1:0] mux_data;

    // The buffer can accept when empty, or when full and draining this cycle.
    assign buf_free = (state == EMPTY) || out_rdy;

`ifdef MUX2_ARB_4B_FIXED_PRIO_EN
    assign grant0 = in0_val;
    assign grant1 = in1_val & ~in0_val;
`else
    // last_grant = 1 means requester 1 won most recently, so requester 0 wins contention.
    logic last_grant;

    assign grant0 = in0_val & (~in1_val |  last_grant);
    assign grant1 = in1_val & (~in0_val | ~last_grant);

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (xfer_in) begin
            last_grant <= in1_rdy;
        end
    end
`endif

    assign in0_rdy = reset & buf_free & grant0;
    assign in1_rdy = reset & buf_free & grant1;
    assign xfer_in = in0_rdy | in1_rdy;

    mux2_arb_4b_mux u_mux (
        .a   (in0_data),
        .b   (in1_data),
        .sel (in1_rdy),
        .y   (mux_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= EMPTY;
            out_data <= '0;
            out_src  <= 1'b0;
            xfer_cnt <= '0;
        end else if (xfer_in) begin
            state    <= FULL;
            out_data <= mux_data;
            out_src  <= in1_rdy;
            xfer_cnt <= sat_inc(xfer_cnt);
        end else if ((state == FULL) && out_rdy) begin
            state    <= EMPTY;
        end
    end

    assign out_val = (state == FULL);

endmodule

// File: tb/tb_mux2_arb_4b.sv
// Directed and randomised checks for mux2_arb_4b: reset, single grant, contention, backpressure,
// counter saturation, and a scoreboarded random run.
module tb_mux2_arb_4b;

    logic       clk;
    logic       reset;
    logic       in0_val;
    logic [3:0] in0_data;
    logic       in0_rdy;
    logic       in1_val;
    logic [3:0] in1_data;
    logic       in1_rdy;
    logic       out_val;
    logic [3:0] out_data;
    logic       out_src;
    logic       out_rdy;
    logic [7:0] xfer_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entries are {src, data}.
    logic [4:0] exp_q[$];

    // Random-run reference state.
    logic       m_full;
    logic       m_last;
    logic [7:0] m_cnt;

    mux2_arb_4b dut (
        .clk      (clk),
        .reset    (reset),
        .in0_val  (in0_val),
        .in0_data (in0_data),
        .in0_rdy  (in0_rdy),
        .in1_val  (in1_val),
        .in1_data (in1_data),
        .in1_rdy  (in1_rdy),
        .out_val  (out_val),
        .out_data (out_data),
        .out_src  (out_src),
        .out_rdy  (out_rdy),
        .xfer_cnt (xfer_cnt)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [3:0] d0, input logic v1,
                         input logic [3:0] d1, input logic ordy);
        in0_val  = v0;
        in0_data = d0;
        in1_val  = v1;
        in1_data = d1;
        out_rdy  = ordy;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [4:0] exp_item;
        logic       e0;
        logic       e1;
        logic       ebk;
        logic [3:0] ebk_data;
        logic       expect_src[4];
        logic [3:0] expect_dat[4];

        reset = 1'b0;
        drive(1'b1, 4'b0101, 1'b1, 4'b1001, 1'b1);

        // Reset held two cycles with both requesters valid.
        tick();
        tick();
        @(negedge clk);
        check("rst_in0_rdy", in0_rdy, 1'b0);
        check("rst_in1_rdy", in1_rdy, 1'b0);
        check("rst_out_val", out_val, 1'b0);
        check("rst_out_data", out_data, 4'b0000);
        check("rst_out_src", out_src, 1'b0);
        check("rst_xfer_cnt", xfer_cnt, 8'd0);

        // Single requester.
        tick();
        reset = 1'b1;
        drive(1'b1, 4'b1011, 1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        check("single_in0_rdy", in0_rdy, 1'b1);
        check("single_in1_rdy", in1_rdy, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
        check("single_out_val", out_val, 1'b1);
        check("single_out_data", out_data, 4'b1011);
        check("single_out_src", out_src, 1'b0);
        check("single_xfer_cnt", xfer_cnt, 8'd1);

        // Contention from a fresh reset: requester 0 takes the first grant.
`ifdef MUX2_ARB_4B_FIXED_PRIO_EN
        expect_src = '{1'b0, 1'b0, 1'b0, 1'b0};
        expect_dat = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
`else
        expect_src = '{1'b0, 1'b1, 1'b0, 1'b1};
        expect_dat = '{4'b0011, 4'b1010, 4'b0011, 4'b1010};
`endif
        do_reset();
        drive(1'b1, 4'b0011, 1'b1, 4'b1010, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("cont_in0_rdy_%0d", k), in0_rdy, !expect_src[k]);
            check($sformatf("cont_in1_rdy_%0d", k), in1_rdy, expect_src[k]);
            tick();
            check($sformatf("cont_out_val_%0d", k), out_val, 1'b1);
            check($sformatf("cont_out_src_%0d", k), out_src, expect_src[k]);
            check($sformatf("cont_out_data_%0d", k), out_data, expect_dat[k]);
        end
        check("cont_xfer_cnt", xfer_cnt, 8'd4);

        // Backpressure: fill with 1110, then stall three cycles with both valid.
        drive(1'b1, 4'b1110, 1'b0, 4'b0000, 1'b1);
        tick();
        check("bp_fill_data", out_data, 4'b1110);
        drive(1'b1, 4'b0101, 1'b1, 4'b0110, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_in0_rdy_%0d", k), in0_rdy, 1'b0);
            check($sformatf("bp_in1_rdy_%0d", k), in1_rdy, 1'b0);
            tick();
            check($sformatf("bp_out_val_%0d", k), out_val, 1'b1);
            check($sformatf("bp_out_data_%0d", k), out_data, 4'b1110);
            check($sformatf("bp_out_src_%0d", k), out_src, 1'b0);
        end
        // Release: requester 0 won last, so round-robin now favours requester 1.
`ifdef MUX2_ARB_4B_FIXED_PRIO_EN
        ebk      = 1'b0;
        ebk_data = 4'b0101;
`else
        ebk      = 1'b1;
        ebk_data = 4'b0110;
`endif
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_rel_in0_rdy", in0_rdy, !ebk);
        check("bp_rel_in1_rdy", in1_rdy, ebk);
        tick();
        check("bp_refill_val", out_val, 1'b1);
        check("bp_refill_data", out_data, ebk_data);
        check("bp_refill_src", out_src, ebk);
        check("bp_xfer_cnt", xfer_cnt, 8'd6);
        // Drain with no refill: buffer empties, payload registers hold.
        drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
        tick();
        check("drain_out_val", out_val, 1'b0);
        check("drain_hold_data", out_data, ebk_data);
        check("drain_hold_src", out_src, ebk);

        // Saturation.
        do_reset();
        drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1);
        for (int k = 0; k < 254; k++) tick();
        check("sat_cnt_254", xfer_cnt, 8'd254);
        tick();
        check("sat_cnt_255", xfer_cnt, 8'd255);
        for (int k = 0; k < 5; k++) tick();
        check("sat_cnt_260", xfer_cnt, 8'd255);

        // Random run against a reference model and scoreboard.
        drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        do_reset();
        m_full = 1'b0;
        m_last = 1'b1;
        m_cnt  = 8'd0;
        exp_q.delete();
        for (int c = 0; c < 200; c++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0));
            @(negedge clk);
`ifdef MUX2_ARB_4B_FIXED_PRIO_EN
            e0 = in0_val;
            e1 = in1_val && !in0_val;
`else
            e0 = in0_val && (!in1_val || m_last);
            e1 = in1_val && (!in0_val || !m_last);
`endif
            e0 = e0 && (!m_full || out_rdy);
            e1 = e1 && (!m_full || out_rdy);
            check("rnd_in0_rdy", in0_rdy, e0);
            check("rnd_in1_rdy", in1_rdy, e1);
            check("rnd_out_val", out_val, m_full);
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_out", 1'b1, 1'b0);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("rnd_out_payload", {out_src, out_data}, exp_item);
                end
            end
            if (e0 || e1) begin
                exp_q.push_back(e1 ? {1'b1, in1_data} : {1'b0, in0_data});
                m_last = e1;
                m_full = 1'b1;
                m_cnt  = (m_cnt == 8'hff) ? m_cnt : m_cnt + 8'd1;
            end else if (out_rdy) begin
                m_full = 1'b0;
            end
            tick();
        end
        drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        check("rnd_xfer_cnt", xfer_cnt, m_cnt);
        check("rnd_final_val", out_val, m_full);
        if (out_val) begin
            if (exp_q.size() == 0) begin
                check("rnd_final_unexpected", 1'b1, 1'b0);
            end else begin
                exp_item = exp_q.pop_front();
                check("rnd_final_payload", {out_src, out_data}, exp_item);
            end
        end
        check("rnd_queue_empty", exp_q.size(), 0);

        // Final report.
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux2_arb_4b.md
MUX2_ARB_4B -- requirements
Module: mux2_arb_4b

Interface
REQ-001 Parameters: none; all data widths SHALL be fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clk.
REQ-004 in0_val  input  1  requester 0 has data.
REQ-005 in0_data  input  4  requester 0 payload.
REQ-006 in0_rdy  output  1  requester 0 transfer accepted this cycle.
REQ-007 in1_val  input  1  requester 1 has data.
REQ-008 in1_data  input  4  requester 1 payload.
REQ-009 in1_rdy  output  1  requester 1 transfer accepted this cycle.
REQ-010 out_val  output  1  output buffer holds valid data.
REQ-011 out_data  output  4  buffered payload.
REQ-012 out_src  output  1  index of the requester that supplied out_data.
REQ-013 out_rdy  input  1  consumer accepts out_data this cycle.
REQ-014 xfer_cnt  output  8  count of accepted input transfers.

Function
REQ-015 An input transfer SHALL occur on a cycle when inX_val=1 and inX_rdy=1; an output transfer when out_val=1 and out_rdy=1.
REQ-016 Block SHALL hold a one-entry output buffer with states EMPTY (out_val=0) and FULL (out_val=1).
REQ-017 Buffer is "free" when state=EMPTY, or when state=FULL and out_rdy=1 (same-cycle drain and refill).
REQ-018 At most one of in0_rdy/in1_rdy SHALL be 1 in any cycle; both SHALL be 0 when the buffer is not free.
REQ-019 inX_rdy SHALL be combinational from in*_val, out_rdy, state and priority pointer; it SHALL NOT depend on inX_data.
REQ-020 When free and exactly one requester is valid, that requester SHALL be granted.
REQ-021 When free and both are valid, the requester NOT granted most recently SHALL be granted (round-robin pointer).
REQ-022 Priority pointer SHALL update only on an input transfer, to the requester just granted.
REQ-023 On an input transfer, the granted payload SHALL be selected by the 2:1 mux (sel = grant index) and registered into out_data, grant index into out_src, state->FULL; latency in-to-out = 1 cycle.
REQ-024 Output transfer with no simultaneous input transfer: state->EMPTY; out_data/out_src SHALL hold last values.
REQ-025 FULL with out_rdy=0: out_data, out_src, out_val SHALL be stable; no grants.
REQ-026 xfer_cnt SHALL increment by 1 per input transfer and saturate at 255 (no wrap).
REQ-027 Sustained throughput SHALL be one transfer per cycle when out_rdy=1 continuously.

Reset
REQ-028 While reset=0 at a rising edge: state=EMPTY, out_val=0, out_data=4'b0000, out_src=0, xfer_cnt=0, pointer set so requester 0 wins the first contended grant.
REQ-029 in0_rdy and in1_rdy SHALL be 0 during any cycle with reset=0.
REQ-030 Reset asserted mid-transfer SHALL discard buffered data; no grant recorded that cycle.

Configuration
REQ-031 Macro MUX2_ARB_4B_FIXED_PRIO_EN: when defined, round-robin SHALL be replaced by fixed priority (requester 0 always wins contention; pointer logic removed); when undefined, REQ-021/022 apply.

Structure
REQ-032 Shared package SHALL hold the state enum (EMPTY, FULL) and constant DATA_W=4.
REQ-033 Data selection SHALL instantiate the team's existing gate-level 2:1 4-bit mux as the one sub-module; no behavioural data mux.

Verification
REQ-034 Reset: hold reset=0 two cycles with in0_val=in1_val=1 -> in*_rdy=0, out_val=0, out_data=0000, xfer_cnt=0.
REQ-035 Single: in0_val=1, in0_data=1011, out_rdy=1 -> in0_rdy=1; next cycle out_val=1, out_data=1011, out_src=0.
REQ-036 Contention: both valid, in0=0011, in1=1010, out_rdy=1 for 4 cycles -> out_src sequence 0,1,0,1; data 0011,1010,0011,1010 (fixed-prio build: all 0).
REQ-037 Backpressure: buffer FULL with 1110, out_rdy=0 three cycles, both valid -> in*_rdy=0, out_data stays 1110; out_rdy=1 -> same-cycle refill.
REQ-038 Saturation: 260 transfers -> xfer_cnt=255.
REQ-039 Random: 200 cycles random val/data/out_rdy against reference model -> no mismatch, no dropped or duplicated payload.
